fc_seq_ctrl: RTL

//  Job sequencer for the 2-output fully-connected engine. On start, it streams NUM_CHUNK 9-byte

---
 rtl/fc_seq_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: job sequencer streaming NUM_CHUNK buffer chunks into the 2-output FC engine.
// Define FC_SEQ_PERF_EN to build the job cycle counter driven on perf_cycles.
module fc_seq_ctrl #(
    parameter int unsigned NUM_CHUNK = 32,
    parameter int unsigned CHUNK_GAP = 13,
    parameter int unsigned DRAIN_LAT = 13,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              buf_rd,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [71:0]       feat_data,
    input  logic [71:0]       wgt1_data,
    input  logic [71:0]       wgt2_data,
    input  logic [31:0]       bias_data,
    output logic              fc_valid_i,
    output logic [71:0]       fc_data_in,
    output logic [71:0]       fc_weight1,
    output logic [71:0]       fc_weight2,
    output logic [31:0]       fc_bias,
    input  logic              fc_valid_o,
    input  logic [7:0]        fc_data1,
    input  logic [7:0]        fc_data2,
    output logic [7:0]        res_data1,
    output logic [7:0]        res_data2,
    output logic              res_err,
    output logic [15:0]       perf_cycles
);

    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(CHUNK_GAP - 4);
    localparam logic [TMR_W-1:0]  DRAIN_LOAD = TMR_W'(DRAIN_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_CHUNK = ADDR_W'(NUM_CHUNK - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        GAP,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] chunk_q, chunk_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              load_en;
    logic              capture_en;

    logic [71:0] fc_data_in_q, fc_weight1_q, fc_weight2_q;
    logic [31:0] fc_bias_q;
    logic [7:0]  res_data1_q, res_data2_q;
    logic        res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chunk_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            tmr_q   <= tmr_d;
        end
    end

    // Timers count down to zero; loaded with (length - 1) on entry to GAP/DRAIN.
    always_comb begin
        state_d    = state_q;
        chunk_d    = chunk_q;
        tmr_d      = tmr_q;
        load_en    = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    tmr_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end else begin
                    chunk_d = chunk_q + ADDR_W'(1);
                    tmr_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    state_d = FETCH;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            DRAIN: begin
                if (tmr_q == '0) begin
                    capture_en = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_data_in_q <= '0;
            fc_weight1_q <= '0;
            fc_weight2_q <= '0;
            fc_bias_q    <= '0;
        end else if (load_en) begin
            fc_data_in_q <= feat_data;
            fc_weight1_q <= wgt1_data;
            fc_weight2_q <= wgt2_data;
            fc_bias_q    <= bias_data;
        end
    end

    // Results are latched on entry to DONE so they are already valid alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data1_q <= '0;
            res_data2_q <= '0;
            res_err_q   <= 1'b0;
        end else if (capture_en) begin
            res_data1_q <= fc_data1;
            res_data2_q <= fc_data2;
            res_err_q   <= ~fc_valid_o;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign buf_rd     = (state_q == FETCH);
    assign fc_valid_i = (state_q == ISSUE);
    assign buf_addr   = chunk_q;
    assign fc_data_in = fc_data_in_q;
    assign fc_weight1 = fc_weight1_q;
    assign fc_weight2 = fc_weight2_q;
    assign fc_bias    = fc_bias_q;
    assign res_data1  = res_data1_q;
    assign res_data2  = res_data2_q;
    assign res_err    = res_err_q;

`ifdef FC_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Accept loads 1 so the value shown in busy cycle n is n; DONE is the last counted cycle.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start) begin
                perf_d = 16'd1;
            end
        end else if (state_q != DONE && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'h0000;
`endif

endmodule
